// File: rtl/video_pkg.sv
// Shared video timing defaults and ball-motion FSM encoding.
// Used by the ball position controller and its per-axis datapath.
package video_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_X,
    MOVE_Y
  } motion_state_e;

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: position, direction and wall-hit pulse.
// Reflects off 0 and MAX; the sum is one bit wider so it cannot wrap.
module ball_axis
  import video_pkg::*;
#(
  parameter int MAX   = 632,
  parameter int SPEED = 2,
  parameter int INIT  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               serve,
  output logic [COORD_W-1:0] pos,
  output logic               dir,
  output logic               hit
);

  localparam logic [COORD_W:0]   MAX_W  = (COORD_W+1)'(MAX);
  localparam logic [COORD_W:0]   SPD_W  = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W-1:0] MAX_C  = COORD_W'(MAX);
  localparam logic [COORD_W-1:0] SPD_C  = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] INIT_C = COORD_W'(INIT);

  logic [COORD_W:0] pos_w;
  logic [COORD_W:0] sum;

  assign pos_w = {1'b0, pos};
  assign sum   = pos_w + SPD_W;

  // Step the position once per strobe, bouncing at either wall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= INIT_C;
      dir <= 1'b0;
      hit <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (serve) begin
        pos <= INIT_C;
        dir <= 1'b0;
      end else if (step) begin
        if (!dir) begin
          if (sum >= MAX_W) begin
            pos <= MAX_C;
            dir <= 1'b1;
            hit <= 1'b1;
          end else begin
            pos <= sum[COORD_W-1:0];
          end
        end else begin
          if (pos_w <= SPD_W) begin
            pos <= '0;
            dir <= 1'b0;
            hit <= 1'b1;
          end else begin
            pos <= pos - SPD_C;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball position controller: vsync edge detect plus a
// three-state sequencer that steps x then y once per frame.
module ball_motion
  import video_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = 8,
  parameter int INIT_X    = 128,
  parameter int INIT_Y    = 128,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vsync,
  input  logic               i_enable,
  input  logic               i_serve,
  output logic [COORD_W-1:0] o_ball_x,
  output logic [COORD_W-1:0] o_ball_y,
  output logic               o_hit_h,
  output logic               o_hit_v,
  output logic               o_frame_done
);

  motion_state_e state;
  motion_state_e state_nx;
  logic          r_vsync_d;
  logic          tick;
  logic          step_x;
  logic          step_y;
  logic          done_nx;

  assign tick = i_vsync & ~r_vsync_d & i_enable;

  // State register, vsync delay and registered frame-done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      r_vsync_d    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nx;
      r_vsync_d    <= i_vsync;
      o_frame_done <= done_nx;
    end
  end

  // Next state and per-axis step strobes; serve aborts any update
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    step_x   = 1'b0;
    step_y   = 1'b0;
    if (i_serve) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick) state_nx = MOVE_X;
        end
        MOVE_X: begin
          step_x   = 1'b1;
          state_nx = MOVE_Y;
        end
        MOVE_Y: begin
          step_y   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  ball_axis #(
    .MAX  (SCREEN_W - BALL_SIZE),
    .SPEED(SPEED_X),
    .INIT (INIT_X)
  ) u_axis_x (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .step (step_x),
    .serve(i_serve),
    .pos  (o_ball_x),
    .dir  (),
    .hit  (o_hit_h)
  );

  ball_axis #(
    .MAX  (SCREEN_H - BALL_SIZE),
    .SPEED(SPEED_Y),
    .INIT (INIT_Y)
  ) u_axis_y (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .step (step_y),
    .serve(i_serve),
    .pos  (o_ball_y),
    .dir  (),
    .hit  (o_hit_v)
  );

endmodule

// File: tb/tb_ball_motion.sv
// Testbench for ball_motion: three parameterisations share stimulus.
// A = defaults, B = starts near right/bottom walls, C = narrow screen.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       enable = 1'b1;
  logic       serve = 1'b0;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic       hha, hva, fda;
  logic       hhb, hvb, fdb;
  logic       hhc, hvc, fdc;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] pa_hh, pa_hv, pa_fd;
  logic [3:0] pb_hh, pb_hv;
  logic [3:0] pc_hh;

  always #5 clk = ~clk;

  ball_motion dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync),
    .i_enable(enable), .i_serve(serve),
    .o_ball_x(xa), .o_ball_y(ya),
    .o_hit_h(hha), .o_hit_v(hva), .o_frame_done(fda)
  );

  ball_motion #(.INIT_X(630), .INIT_Y(470)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync),
    .i_enable(enable), .i_serve(serve),
    .o_ball_x(xb), .o_ball_y(yb),
    .o_hit_h(hhb), .o_hit_v(hvb), .o_frame_done(fdb)
  );

  ball_motion #(.SCREEN_W(17), .INIT_X(8)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync),
    .i_enable(enable), .i_serve(serve),
    .o_ball_x(xc), .o_ball_y(yc),
    .o_hit_h(hhc), .o_hit_v(hvc), .o_frame_done(fdc)
  );

  typedef struct {
    logic [9:0] ax, ay, bx, by, cx;
    logic [3:0] b_hh, b_hv, c_hh;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One vsync pulse; record which of the four samples after
  // edges N..N+3 carried each pulse.
  task automatic run_frame();
    pa_hh = '0; pa_hv = '0; pa_fd = '0;
    pb_hh = '0; pb_hv = '0; pc_hh = '0;
    @(negedge clk);
    vsync = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      vsync = 1'b0;
      pa_hh[s] = hha; pa_hv[s] = hva; pa_fd[s] = fda;
      pb_hh[s] = hhb; pb_hv[s] = hvb;
      pc_hh[s] = hhc;
    end
  endtask

  initial begin
    int cnt;
    logic [9:0] x0;

    for (int k = 0; k < 7; k++) begin
      vt[k].ax   = 10'(130 + 2 * k);
      vt[k].ay   = 10'(130 + 2 * k);
      vt[k].bx   = (k == 0) ? 10'd632 : 10'(632 - 2 * k);
      vt[k].by   = (k == 0) ? 10'd472 : 10'(472 - 2 * k);
      vt[k].b_hh = (k == 0) ? 4'b0010 : 4'b0000;
      vt[k].b_hv = (k == 0) ? 4'b0100 : 4'b0000;
      vt[k].c_hh = (k == 0 || k == 5) ? 4'b0010 : 4'b0000;
    end
    vt[0].cx = 10'd9;
    vt[1].cx = 10'd7;
    vt[2].cx = 10'd5;
    vt[3].cx = 10'd3;
    vt[4].cx = 10'd1;
    vt[5].cx = 10'd0;
    vt[6].cx = 10'd2;

    repeat (3) @(negedge clk);
    chk("rst_xa", xa, 128);
    chk("rst_ya", ya, 128);
    chk("rst_xb", xb, 630);
    chk("rst_yb", yb, 470);
    chk("rst_pulses", {hha, hva, fda}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      run_frame();
      chk($sformatf("v%0d_xa", k), xa, vt[k].ax);
      chk($sformatf("v%0d_ya", k), ya, vt[k].ay);
      chk($sformatf("v%0d_fda", k), pa_fd, 4'b0100);
      chk($sformatf("v%0d_hita", k), pa_hh | pa_hv, 0);
      chk($sformatf("v%0d_xb", k), xb, vt[k].bx);
      chk($sformatf("v%0d_yb", k), yb, vt[k].by);
      chk($sformatf("v%0d_hhb", k), pb_hh, vt[k].b_hh);
      chk($sformatf("v%0d_hvb", k), pb_hv, vt[k].b_hv);
      chk($sformatf("v%0d_xc", k), xc, vt[k].cx);
      chk($sformatf("v%0d_hhc", k), pc_hh, vt[k].c_hh);
    end

    x0 = xa;
    cnt = 0;
    @(negedge clk);
    vsync = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (fda) cnt++;
    end
    vsync = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (fda) cnt++;
    end
    chk("hold_done_cnt", cnt, 1);
    chk("hold_xa", xa, 10'(x0 + 2));

    x0 = xa;
    cnt = 0;
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vsync = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (fda) cnt++;
      end
      vsync = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (fda) cnt++;
      end
    end
    enable = 1'b1;
    chk("dis_done_cnt", cnt, 0);
    chk("dis_xa", xa, x0);

    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
    chk("srv_xa", xa, 128);
    chk("srv_ya", ya, 128);
    chk("srv_xb", xb, 630);
    chk("srv_yb", yb, 470);
    chk("srv_pulse0", {hha, hva, fda, hhb, hvb}, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (hha | hva | fda | hhb | hvb) cnt++;
    end
    chk("srv_pulses", cnt, 0);
    chk("srv_hold_xa", xa, 128);
    run_frame();
    chk("srv_next_xa", xa, 130);
    chk("srv_next_fd", pa_fd, 4'b0100);

    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    chk("pre_rst_xa", xa, 132);
    rst_n = 1'b0;
    #1;
    chk("mrst_xa", xa, 128);
    chk("mrst_ya", ya, 128);
    chk("mrst_pulses", {hha, hva, fda}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (hha | hva | fda) cnt++;
    end
    chk("mrst_quiet", cnt, 0);
    run_frame();
    chk("mrst_next_xa", xa, 130);
    chk("mrst_next_ya", ya, 130);
    chk("mrst_next_fd", pa_fd, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Frame-rate ball position controller that sits directly upstream of the ball renderer. It advances a ball's (x, y) coordinates once per video frame on the rising edge of vsync from `video_sync_generator`. It reflects the ball off the four screen edges and reports wall hits as single-cycle pulses. The renderer compares `o_ball_x`/`o_ball_y` against the beam position to draw the ball.

## Interface

Parameters:
- `SCREEN_W`, 640: active width in pixels.
- `SCREEN_H`, 480: active height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `INIT_X`, 128: x coordinate after reset or serve.
- `INIT_Y`, 128: y coordinate after reset or serve.
- `SPEED_X`, 2: pixels per frame on x. Legal range is 1..`BALL_SIZE`.
- `SPEED_Y`, 2: pixels per frame on y. Legal range is 1..`BALL_SIZE`.

Ports:
- `i_clk`, in, 1: pixel clock, the only clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_vsync`, in, 1: active-high vsync from `video_sync_generator`, in the same clock domain.
- `i_enable`, in, 1: when low, frame ticks are ignored and position holds.
- `i_serve`, in, 1: synchronous restart to the initial position and direction.
- `o_ball_x`, out, 10: left edge of the ball.
- `o_ball_y`, out, 10: top edge of the ball.
- `o_hit_h`, out, 1: one-cycle pulse on a left or right wall bounce.
- `o_hit_v`, out, 1: one-cycle pulse on a top or bottom wall bounce.
- `o_frame_done`, out, 1: one-cycle pulse when the per-frame update completes.

## Operation

- `r_vsync_d` registers `i_vsync`. `tick = i_vsync & ~r_vsync_d & i_enable`.
- The FSM has three states: IDLE, MOVE_X, MOVE_Y.
  - IDLE → MOVE_X on `tick`.
  - MOVE_X → MOVE_Y unconditionally.
  - MOVE_Y → IDLE unconditionally, with a pulse on `o_frame_done`.
  - `tick` is ignored outside IDLE.
- Each axis holds a position `pos` and a direction bit (0 = increasing). `MAX = SCREEN_x − BALL_SIZE`.
- Increasing direction, evaluated in its MOVE state:
  - If `pos + SPEED >= MAX`: `pos <= MAX`, direction flips, and the hit pulse fires.
  - Otherwise `pos <= pos + SPEED`.
- Decreasing direction, evaluated in its MOVE state:
  - If `pos <= SPEED`: `pos <= 0`, direction flips, and the hit pulse fires.
  - Otherwise `pos <= pos − SPEED`.
- Arithmetic:
  - The sum is computed at 11 bits so it cannot wrap.
  - The decreasing compare is done before subtraction, so the result is never negative.
  - Stored positions are 10 bits and always lie in 0..MAX.
- `i_serve`, sampled on any cycle:
  - Position goes to `INIT_X`, `INIT_Y`; both directions go to 0; the FSM goes to IDLE.
  - No hit or done pulse fires.
  - It takes priority over a simultaneous `tick` or an in-progress update; that frame's update is dropped.
- Corner case: X and Y are evaluated independently, so both `o_hit_h` (from MOVE_X) and `o_hit_v` (from MOVE_Y) fire within the same frame.
- Reset values:
  - `o_ball_x = INIT_X`, `o_ball_y = INIT_Y`.
  - Both directions 0.
  - `o_hit_h`, `o_hit_v`, `o_frame_done` all 0.
  - FSM in IDLE, `r_vsync_d = 0`.
- Reset mid-update: the FSM returns to IDLE immediately and the partial update is discarded.

## Timing

- Let edge N be the clock edge at which `i_vsync = 1` and `r_vsync_d = 0`. The update then proceeds as follows:
  - After edge N: state is MOVE_X.
  - After edge N+1: `o_ball_x` is updated and `o_hit_h` is valid for one cycle.
  - After edge N+2: `o_ball_y` is updated, `o_hit_v` and `o_frame_done` are valid for one cycle, and state is IDLE.
- Total latency is 3 cycles, well inside vblank. Because the update completes inside vblank, the renderer never sees a torn position during active video.
- All outputs are registered and change only on `i_clk` edges, apart from the asynchronous reset.

## Structure

- A shared package `video_pkg` holds:
  - `SCREEN_W`/`SCREEN_H` defaults.
  - `COORD_W = 10`.
  - The FSM state typedef: IDLE, MOVE_X, MOVE_Y.
- Sub-module `ball_axis` is instantiated twice (x, y):
  - Parameters: MAX, SPEED, INIT.
  - Inputs: step strobe and serve.
  - Outputs: position, direction, hit pulse.
  - The top holds only the edge detector and the FSM, which drives each axis's step strobe in its MOVE state.

## Test plan

- Reset, then one vsync rise with `i_enable = 1` → after 3 cycles x = 130, y = 130, a single `o_frame_done` pulse, no hits.
- `INIT_X = 630` → first tick gives x = 632 with `o_hit_h`; second tick gives x = 630.
- Drive the ball to x = 1 moving left → next tick gives x = 0 with `o_hit_h`; following tick gives x = 2.
- `INIT_X = 630`, `INIT_Y = 470` → first tick gives x = 632, y = 472, `o_hit_h` one cycle before `o_hit_v`.
- Hold vsync high for 100 cycles, and separately toggle it with `i_enable = 0` → exactly one update in the first case, none in the second.
- Assert `i_serve` in MOVE_X, and separately assert `i_rst_n = 0` in MOVE_Y → in both cases x = 128, y = 128, state IDLE, no pulses.
